// File: rtl/lcd_byte_writer.sv
// Post-init HD44780 4-bit byte writer: one byte per valid/ready handshake, high nibble then low nibble.
// Build option LCD_LONG_CMD_DELAY_EN: clear/home instructions wait CLR_CYC instead of EXEC_CYC.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for a byte; in_ready follows init_done
// SETUP_HI | RS and high nibble driven, E low
// PULSE_HI | E high for the high nibble
// GAP      | E low between the two nibbles
// SETUP_LO | low nibble driven, E low
// PULSE_LO | E high for the low nibble
// EXEC     | LCD execution wait, E low
module lcd_byte_writer #(
    parameter int E_SETUP_CYC = 5,
    parameter int E_HIGH_CYC  = 50,
    parameter int E_GAP_CYC   = 50,
    parameter int EXEC_CYC    = 4000,
    parameter int CLR_CYC     = 164000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       init_done,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic       RS,
    output logic       E,
    output logic       DB7,
    output logic       DB6,
    output logic       DB5,
    output logic       DB4
);

    localparam int MAX_CYC = (CLR_CYC > EXEC_CYC) ? CLR_CYC : EXEC_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(E_SETUP_CYC - 1);
    localparam logic [CW-1:0] HIGH_LD  = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(E_GAP_CYC - 1);
    localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
`ifdef LCD_LONG_CMD_DELAY_EN
    localparam logic [CW-1:0] CLR_LD   = CW'(CLR_CYC - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        SETUP_HI,
        PULSE_HI,
        GAP,
        SETUP_LO,
        PULSE_LO,
        EXEC
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            rs_q;
    logic [7:0]      data_q;
    logic [3:0]      db;
    logic [CW-1:0]   exec_ld;
    logic            accept;

    assign accept = in_valid & in_ready;
    assign {DB7, DB6, DB5, DB4} = db;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    always_comb begin
        exec_ld = EXEC_LD;
`ifdef LCD_LONG_CMD_DELAY_EN
        if (!rs_q && (data_q[7:2] == 6'b000000)) begin
            exec_ld = CLR_LD;
        end
`endif
    end

    // Pin outputs are registered from the current state, so they trail the
    // state by one cycle; every phase therefore keeps its full duration.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            RS       <= 1'b0;
            E        <= 1'b0;
            db       <= 4'h0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
        end else if (!init_done) begin
            // Abort: drop the byte, leave RS/DB where they were.
            state    <= IDLE;
            E        <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            E        <= (state == PULSE_HI) || (state == PULSE_LO);
            busy     <= (state != IDLE);
            in_ready <= (state == IDLE) && !accept;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rs_q   <= in_rs;
                        data_q <= in_data;
                        state  <= SETUP_HI;
                        cnt    <= SETUP_LD;
                    end
                end
                SETUP_HI: begin
                    RS <= rs_q;
                    db <= data_q[7:4];
                    if (cnt == '0) begin
                        state <= PULSE_HI;
                        cnt   <= HIGH_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE_HI: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        cnt   <= GAP_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= SETUP_LO;
                        cnt   <= SETUP_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETUP_LO: begin
                    db <= data_q[3:0];
                    if (cnt == '0) begin
                        state <= PULSE_LO;
                        cnt   <= HIGH_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE_LO: begin
                    if (cnt == '0) begin
                        state <= EXEC;
                        cnt   <= exec_ld;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Testbench for lcd_byte_writer: scoreboard of expected E pulses (RS, nibble, rise cycle)
// plus per-scenario handshake timing checks.
module tb_lcd_byte_writer;

    logic       clk;
    logic       nrst;
    logic       init_done;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic       busy;
    logic       RS;
    logic       E;
    logic       DB7, DB6, DB5, DB4;

    localparam int READY_LAT = 4161;
`ifdef LCD_LONG_CMD_DELAY_EN
    localparam int CLR_READY_LAT = 164161;
`else
    localparam int CLR_READY_LAT = 4161;
`endif
    localparam int BOUND = 170000;

    lcd_byte_writer dut (
        .clk       (clk),
        .nrst      (nrst),
        .init_done (init_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs     (in_rs),
        .in_data   (in_data),
        .busy      (busy),
        .RS        (RS),
        .E         (E),
        .DB7       (DB7),
        .DB6       (DB6),
        .DB5       (DB5),
        .DB4       (DB4)
    );

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_pass;
    int   n_total;
    logic e_prev;
    logic [4:0] rise_val;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // E pulse monitor: each rising E pops one expectation; RS/DB must not move while E is high.
    always @(negedge clk) begin
        exp_t ex;
        if (nrst && E && !e_prev) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_e_pulse: E rose at cycle %0d with RS/DB=%h, none expected", cyc, {RS, DB7, DB6, DB5, DB4});
            end else begin
                ex = sb.pop_front();
                if ({RS, DB7, DB6, DB5, DB4} !== {ex.rs, ex.nib} || cyc != ex.cyc)
                    $display("FAIL e_pulse: got RS/DB=%h at cycle %0d, expected %h at cycle %0d",
                             {RS, DB7, DB6, DB5, DB4}, cyc, {ex.rs, ex.nib}, ex.cyc);
                else
                    n_pass++;
            end
            rise_val = {RS, DB7, DB6, DB5, DB4};
        end
        if (nrst && !E && e_prev) begin
            n_total++;
            if ({RS, DB7, DB6, DB5, DB4} !== rise_val)
                $display("FAIL db_stable_during_e: RS/DB=%h at E fall, was %h at E rise", {RS, DB7, DB6, DB5, DB4}, rise_val);
            else
                n_pass++;
        end
        e_prev = nrst ? E : 1'b0;
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_ready(output int c);
        c = -1;
        for (int i = 0; i < BOUND; i++) begin
            if (in_ready === 1'b1) begin
                c = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge t.
    task automatic accept_byte(input logic rs, input logic [7:0] d, input bit hold,
                               input bit push_lo, output int t);
        exp_t ex;
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        t = -1;
        for (int i = 0; i < BOUND; i++) begin
            if (in_ready === 1'b1) break;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1 within %0d cycles", in_ready, BOUND);
            in_valid = 1'b0;
            return;
        end
        t = cyc + 1;
        ex.rs = rs; ex.nib = d[7:4]; ex.cyc = t + 6;
        sb.push_back(ex);
        if (push_lo) begin
            ex.nib = d[3:0]; ex.cyc = t + 111;
            sb.push_back(ex);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic test_reset;
        nrst      = 1'b0;
        init_done = 1'b0;
        in_valid  = 1'b0;
        in_rs     = 1'b0;
        in_data   = 8'h00;
        #20;
        n_total++;
        if ({RS, E, DB7, DB6, DB5, DB4, in_ready, busy} !== 8'h00)
            $display("FAIL reset_outputs: got %b, expected 00000000", {RS, E, DB7, DB6, DB5, DB4, in_ready, busy});
        else n_pass++;
        #30;
        nrst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            repeat (20) @(negedge clk);
            n_total++;
            if ({RS, E, DB7, DB6, DB5, DB4, in_ready, busy} !== 8'h00)
                $display("FAIL hold_no_init: got %b, expected 00000000", {RS, E, DB7, DB6, DB5, DB4, in_ready, busy});
            else n_pass++;
        end
    endtask

    task automatic test_data_byte;
        int t, c;
        init_done = 1'b1;
        accept_byte(1'b1, 8'h41, 0, 1, t);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL ready_drop: in_ready=%b after accept, expected 0", in_ready);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL busy_during: busy=%b, expected 1", busy);
        else n_pass++;
        wait_ready(c);
        n_total++;
        if (c != t + READY_LAT) $display("FAIL data_ready_time: ready at %0d, expected %0d", c, t + READY_LAT);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL busy_after: busy=%b, expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int t1, t2, c;
        accept_byte(1'b1, 8'h48, 1, 1, t1);
        accept_byte(1'b1, 8'h49, 0, 1, t2);
        n_total++;
        if (t2 != t1 + READY_LAT + 1) $display("FAIL b2b_accept: second accept at %0d, expected %0d", t2, t1 + READY_LAT + 1);
        else n_pass++;
        wait_ready(c);
        n_total++;
        if (c != t2 + READY_LAT) $display("FAIL b2b_ready_time: ready at %0d, expected %0d", c, t2 + READY_LAT);
        else n_pass++;
    endtask

    task automatic test_clear_cmd;
        int t, c;
        accept_byte(1'b0, 8'h01, 0, 1, t);
        wait_ready(c);
        n_total++;
        if (c != t + CLR_READY_LAT) $display("FAIL clear_ready_time: ready at %0d, expected %0d", c, t + CLR_READY_LAT);
        else n_pass++;
    endtask

    task automatic test_abort;
        int t;
        accept_byte(1'b1, 8'h5A, 0, 0, t);
        wait_cyc(t + 20);
        init_done = 1'b0;
        @(negedge clk);
        n_total++;
        if ({E, busy, in_ready} !== 3'b000) $display("FAIL abort_outputs: E/busy/ready=%b, expected 000", {E, busy, in_ready});
        else n_pass++;
        n_total++;
        if ({RS, DB7, DB6, DB5, DB4} !== 5'b10101) $display("FAIL abort_hold_db: RS/DB=%b, expected 10101", {RS, DB7, DB6, DB5, DB4});
        else n_pass++;
        repeat (10) @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL abort_reready: in_ready=%b, expected 1", in_ready);
        else n_pass++;
        repeat (300) @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL abort_no_resend: busy=%b, expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        int t, c;
        accept_byte(1'b1, 8'h33, 0, 1, t);
        wait_cyc(t + 1000);
        #2 nrst = 1'b0;
        #1;
        n_total++;
        if ({RS, E, DB7, DB6, DB5, DB4, in_ready, busy} !== 8'h00)
            $display("FAIL async_reset: got %b before next edge, expected 00000000", {RS, E, DB7, DB6, DB5, DB4, in_ready, busy});
        else n_pass++;
        repeat (3) @(negedge clk);
        #2 nrst = 1'b1;
        @(negedge clk);
        accept_byte(1'b1, 8'hC6, 0, 1, t);
        wait_ready(c);
        n_total++;
        if (c != t + READY_LAT) $display("FAIL post_reset_ready_time: ready at %0d, expected %0d", c, t + READY_LAT);
        else n_pass++;
    endtask

    initial begin
        cyc = 0; n_pass = 0; n_total = 0; e_prev = 1'b0; rise_val = '0;
        test_reset;
        test_data_byte;
        test_back_to_back;
        test_clear_cmd;
        test_abort;
        test_async_reset;
        repeat (5) @(negedge clk);
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d pulses outstanding, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lcd_byte_writer.md
Name: lcd_byte_writer

Overview:
- Post-initialisation byte transmitter for the HD44780-style dot-matrix LCD on the 4-bit bus.
- Takes over the RS/E/DB7..DB4 pins once the 4-bit init sequencer asserts init_done.
- Accepts one 8-bit command or data byte per valid/ready handshake and sends it as high nibble then low nibble, with E pulse timing and post-instruction execution delay.
- Upstream text/command sequencers feed it; the board top muxes its pins with the init block's pins on init_done.

Parameters:
- E_SETUP_CYC, 5: cycles RS/DB are stable with E low before E rises. Minimum 1.
- E_HIGH_CYC, 50: cycles E is held high per nibble (500 ns at 100 MHz). Minimum 1.
- E_GAP_CYC, 50: cycles E is low between high-nibble fall and low-nibble setup. Minimum 1.
- EXEC_CYC, 4000: execution wait after low-nibble E falls (40 us). Minimum 1.
- CLR_CYC, 164000: execution wait for clear/home commands (1.64 ms). Used only with the optional feature.

Ports:
- clk  in  1  system clock, 100 MHz
- nrst  in  1  asynchronous active-low reset
- init_done  in  1  high once the 4-bit init sequence is complete; level
- in_valid  in  1  byte request
- in_ready  out  1  block can accept a byte this cycle
- in_rs  in  1  0 = instruction, 1 = data
- in_data  in  8  byte to send
- busy  out  1  transfer or execution wait in progress
- RS  out  1  LCD register select
- E  out  1  LCD enable strobe
- DB7, DB6, DB5, DB4  out  1 each  LCD data nibble

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on nrst.
- All outputs are registered. On reset: RS=0, E=0, DB7..DB4=0, in_ready=0, busy=0, FSM=IDLE, counter=0.
- in_ready = (state==IDLE) & init_done, registered.
- busy = (state != IDLE).
- A transfer is accepted on a rising edge where in_valid & in_ready. in_rs and in_data are latched at that edge. in_valid without in_ready is ignored, with no queueing.
- Single down-counter, width $clog2(max(CLR_CYC,EXEC_CYC)+1). It is loaded on each state entry with (duration-1) and the state advances when count==0.
- States and timing, with accept edge = T:
  - SETUP_HI (E_SETUP_CYC cycles): RS=in_rs, DB=data[7:4], E=0.
  - PULSE_HI (E_HIGH_CYC): E=1, RS/DB held. E rises at T+1+E_SETUP_CYC.
  - GAP (E_GAP_CYC): E=0, RS/DB held.
  - SETUP_LO (E_SETUP_CYC): DB=data[3:0], E=0.
  - PULSE_LO (E_HIGH_CYC): E=1.
  - EXEC (wait cycles): E=0, RS/DB held.
  - Then IDLE.
- Default timing from accept edge T:
  - E high over [T+6, T+56).
  - Low nibble driven from T+106.
  - E high over [T+111, T+161).
  - in_ready high again at T+4161.
- RS/DB only change while E=0. E is never high for fewer than E_HIGH_CYC cycles except on abort.
- init_done falling in any state: next edge forces IDLE, E=0, in_ready=0. RS/DB keep their last values and the latched byte is discarded.
- Reset mid-transfer: immediate return to the reset values, independent of clk.
- Back-to-back requests: in_valid held high with new data is accepted on the first cycle in_ready is high. No extra bubble beyond the registered in_ready.

Optional Feature:
- Macro: LCD_LONG_CMD_DELAY_EN.
- Defined: EXEC uses CLR_CYC when in_rs==0 and in_data[7:2]==6'b000000 (clear display 0x01, return home 0x02/0x03). All other bytes use EXEC_CYC.
- Undefined: every byte uses EXEC_CYC and the CLR_CYC parameter is unused.

Test Plan:
- Reset and hold: nrst=0 for 50 ns, then init_done=0 for 1 us → all outputs 0, in_ready stays 0.
- Data byte: init_done=1, send in_rs=1, in_data=0x41 at edge T
  - → E high [T+6, T+56) with DB=4'h4, RS=1
  - → E high [T+111, T+161) with DB=4'h1
  - → in_ready=1 at T+4161.
- Back-to-back: in_valid held high with 0x48 then 0x49 → second accept exactly at first-ready edge. Nibbles 4,8,4,9 in order; no E pulse overlaps a DB change.
- Clear command: in_rs=0, in_data=0x01
  - → with LCD_LONG_CMD_DELAY_EN: in_ready returns at T+164161
  - → without it: T+4161.
- Abort: drop init_done during PULSE_HI → next edge E=0, busy=0, in_ready=0. Raising init_done again gives in_ready=1 one cycle later, and the aborted byte is not resent.
- Async reset mid-EXEC: nrst low between clock edges → outputs reach reset values before the next clk edge. A subsequent byte after release is timed from the fresh accept.
